// File: rtl/demux_1x16_ctrl.sv
// demux_1x16_ctrl: sequencer for the 1x16 demux datapath.
// Takes one word with a 4-bit destination over valid/ready. It then holds the
// word and the demux select stable until the addressed sink accepts it. A sink
// that stalls for TIMEOUT cycles has the word dropped and counted, so one dead
// channel cannot block the others.
module demux_1x16_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_dest,
  input  logic [15:0]       dst_ready,
  output logic [15:0]       out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        sel,
  output logic              busy,
  output logic              drop,
  output logic [CNT_W-1:0]  drop_count
);

  // The wait counter only has to reach TIMEOUT-1, because the timeout fires on that value.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              state_q;
  logic [3:0]          sel_q;
  logic [DATA_W-1:0]   data_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                drop_q;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_d;

  logic                sink_ready;
  logic                take;
  logic                timeout_hit;

  assign sink_ready  = dst_ready[sel_q];
  assign take        = in_valid && (state_q == S_IDLE);
  assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == WAIT_LAST) && !sink_ready;

  // Saturating increment of the drop counter; it sticks at all-ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    drop_cnt_d = drop_cnt_q;
    if (drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Two-state FSM, with the select, data, wait counter and drop flags registered.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register is reset here. This is a handful of flops and not a memory, so reset is cheap and makes power-up deterministic.
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      drop_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            sel_q      <= in_dest;
            data_q     <= in_data;
            wait_cnt_q <= '0;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (sink_ready) begin
            // An accept wins over a timeout on the same edge.
            state_q <= S_IDLE;
          end else if (timeout_hit) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q == S_HOLD);
  assign out_valid  = busy ? (16'h0001 << sel_q) : 16'h0000;
  assign out_data   = data_q;
  assign sel        = sel_q;
  assign drop       = drop_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_demux_1x16_ctrl.sv
// Testbench for demux_1x16_ctrl. A transaction-level model predicts how long
// each word is held, whether it is dropped, and the saturating drop count.
module tb_demux_1x16_ctrl;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        in_dest;
  logic [15:0]       dst_ready;
  logic [15:0]       out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        sel;
  logic              busy;
  logic              drop;
  logic [CNT_W-1:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int m_drop_count = 0;

  demux_1x16_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
    .dst_ready(dst_ready), .out_valid(out_valid), .out_data(out_data), .sel(sel),
    .busy(busy), .drop(drop), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  // Sends one word. The sink holds its ready low for 'stalls' HOLD cycles and then raises it.
  // The model: the word is accepted after 'stalls' stall edges, unless TIMEOUT stalls come first.
  task automatic send(input logic [7:0] data, input logic [3:0] dest, input int stalls,
                      input string name);
    logic [15:0] rdy;
    logic [15:0] onehot;
    bit          dropped;
    bit          done;
    onehot  = 16'h0001 << dest;
    dropped = 1'b0;
    done    = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s pre in_ready: got %b want 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_data   = data;
    in_dest   = dest;
    dst_ready = 16'h0000;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, sel, busy, in_ready, drop} !== {onehot, data, dest, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s hold k=%0d: got ov=%h od=%h sel=%h busy=%b rdy=%b drop=%b want ov=%h od=%h sel=%h busy=1 rdy=0 drop=0",
                 name, k, out_valid, out_data, sel, busy, in_ready, drop, onehot, data, dest);
      end
      // Upstream may wiggle freely in HOLD; nothing may be taken.
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_dest  = 4'($urandom);
      rdy      = 16'($urandom);
      rdy[dest] = (k >= stalls);
      dst_ready = rdy;
      if (k >= stalls) begin
        done = 1'b1;
      end else if (TIMEOUT != 0 && k == TIMEOUT - 1) begin
        done    = 1'b1;
        dropped = 1'b1;
      end
    end
    if (dropped && m_drop_count < CNT_MAX) m_drop_count++;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, sel, busy, in_ready, drop, drop_count} !==
        {16'h0000, data, dest, 1'b0, 1'b1, dropped, CNT_W'(m_drop_count)}) begin
      errors++;
      $display("FAIL %s post: got ov=%h od=%h sel=%h busy=%b rdy=%b drop=%b cnt=%0d want ov=0000 od=%h sel=%h busy=0 rdy=1 drop=%b cnt=%0d",
               name, out_valid, out_data, sel, busy, in_ready, drop, drop_count, data, dest, dropped, m_drop_count);
    end
    in_valid  = 1'b0;
    dst_ready = 16'($urandom);
    @(negedge clk);
    checks++;
    if ({drop, in_ready, out_valid} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL %s idle: got drop=%b rdy=%b ov=%h want drop=0 rdy=1 ov=0000",
               name, drop, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; dst_ready = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_drop_count = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, sel, drop_count, busy, drop, out_data} !==
        {1'b1, 16'h0000, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: got rdy=%b ov=%h sel=%h cnt=%0d busy=%b drop=%b od=%h want rdy=1 ov=0000 sel=0 cnt=0 busy=0 drop=0 od=00",
               in_ready, out_valid, sel, drop_count, busy, drop, out_data);
    end
  endtask

  task automatic test_basic();
    send(8'hA5, 4'd9, 0, "basic_d9");
    send(8'h3C, 4'd3, 5, "stall5_d3");
    send(8'h00, 4'd0, 0, "edge_d0");
  endtask

  // Two words offered back to back: in_ready must return two cycles after each handshake.
  task automatic test_back_to_back();
    logic [15:0] st;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h11; in_dest = 4'd2; dst_ready = 16'hFFFF;
    st = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      st[c] = in_ready;
      if (c == 0) begin
        in_data = 8'h22; in_dest = 4'd14;
        checks++;
        if ({out_valid, out_data} !== {16'h0004, 8'h11}) begin
          errors++;
          $display("FAIL b2b word1: got ov=%h od=%h want ov=0004 od=11", out_valid, out_data);
        end
      end
      if (c == 2) begin
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, sel} !== {16'h4000, 8'h22, 4'd14}) begin
          errors++;
          $display("FAIL b2b word2: got ov=%h od=%h sel=%h want ov=4000 od=22 sel=e", out_valid, out_data, sel);
        end
      end
    end
    checks++;
    if (st[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL b2b in_ready pattern: got %b want 1010", st[3:0]);
    end
  endtask

  task automatic test_timeout();
    send(8'h5A, 4'd15, 1000, "timeout_d15");
    send(8'h77, 4'd15, TIMEOUT - 1, "last_edge_accept");
    send(8'h78, 4'd7, TIMEOUT - 2, "near_timeout");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 4'($urandom), int'($urandom_range(0, 20)), "random");
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      send(8'($urandom), 4'd6, 1000, "saturate");
    end
    checks++;
    if (drop_count !== 8'hFF) begin
      errors++;
      $display("FAIL saturate final: got %h want ff", drop_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hC3; in_dest = 4'd12; dst_ready = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    m_drop_count = 0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, drop, drop_count} !== {16'h0000, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL async reset: got ov=%h rdy=%b busy=%b drop=%b cnt=%0d want ov=0000 rdy=1 busy=0 drop=0 cnt=0",
               out_valid, in_ready, busy, drop, drop_count);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h96, 4'd1, 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_random();
    test_saturate();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
